serial_pattern_detector: RTL

- Parametrised successor to the fixed six-state serial Mealy-style detector.
- Detects a run-time-loadable WIDTH-bit pattern on serial input w, in overlapping or non-overlapping mode.
- Gates bit sampling with an enable and keeps a saturating match counter.
- Sits on a serial bit stream; feeds status/interrupt logic with the z pulse and Count.

---
 rtl/serial_pattern_detector.sv | 106 ++++++++++
 1 files changed

// File: rtl/serial_pattern_detector.sv
// Serial pattern detector with a run-time loadable WIDTH-bit pattern,
// overlapping / non-overlapping match modes, bit-enable gating and a
// saturating match counter.
module serial_pattern_detector #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] Pattern,
  input  logic             En,
  input  logic             w,
  input  logic             Overlap,
  output logic             z,
  output logic [CNT_W-1:0] Count,
  output logic             Armed
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam logic [FW-1:0] FILL_LAST = FW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] pat_reg, pat_n;
  logic [WIDTH-1:0] hist, hist_n;
  logic [WIDTH-1:0] hist_shift;
  logic [FW-1:0]    fill, fill_n;
  logic [CNT_W-1:0] count_n;
  logic             z_n;
  logic             do_cmp;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign hist_shift = {hist[WIDTH-2:0], w};
  assign Armed      = (state == FILL) || (state == RUN);

  // State and datapath registers; reset clears everything including the pattern.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      pat_reg <= '0;
      hist    <= '0;
      fill    <= '0;
      Count   <= '0;
      z       <= 1'b0;
    end else begin
      state   <= state_n;
      pat_reg <= pat_n;
      hist    <= hist_n;
      fill    <= fill_n;
      Count   <= count_n;
      z       <= z_n;
    end
  end

  // Next-state logic: Load re-arms, En shifts a bit in and compares once the window is full.
  always_comb begin
    state_n = state;
    pat_n   = pat_reg;
    hist_n  = hist;
    fill_n  = fill;
    count_n = Count;
    z_n     = 1'b0;
    do_cmp  = 1'b0;
    if (Load) begin
      pat_n   = Pattern;
      hist_n  = '0;
      fill_n  = '0;
      count_n = '0;
      state_n = FILL;
    end else if (En) begin
      case (state)
        FILL: begin
          hist_n = hist_shift;
          fill_n = fill + FW'(1);
          if (fill == FILL_LAST) begin
            do_cmp  = 1'b1;
            state_n = RUN;
          end
        end
        RUN: begin
          hist_n = hist_shift;
          do_cmp = 1'b1;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
      if (do_cmp && (hist_shift == pat_reg)) begin
        z_n     = 1'b1;
        count_n = sat_inc(Count);
        // Non-overlapping mode: the next match must be built from fresh bits.
        if (!Overlap) begin
          fill_n  = '0;
          state_n = FILL;
        end
      end
    end
  end

endmodule
